// File: rtl/cpu_axi_program_loader.sv
// cpu_axi_program_loader: AXI-Lite master that halts the CPU, streams a program
// into its instruction window, sets the PC and restarts it.
// Optional build macro CPU_LOADER_READBACK_EN: read back and compare every
// program word before counting it as loaded.
module cpu_axi_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] INSTR_OFF = 32'h0000_0040,
  parameter int          MAX_WORDS = 16,
  parameter logic [31:0] START_PC  = 32'h0000_0000,
  parameter logic [31:0] RUN_CTRL  = 32'h0000_0001
) (
  input  logic                           M_AXI_ACLK,
  input  logic                           M_AXI_ARESET,
  input  logic                           start,
  input  logic                           s_word_valid,
  output logic                           s_word_ready,
  input  logic [31:0]                    s_word_data,
  input  logic                           s_word_last,
  output logic [31:0]                    M_AXI_AWADDR,
  output logic                           M_AXI_AWVALID,
  input  logic                           M_AXI_AWREADY,
  output logic [31:0]                    M_AXI_WDATA,
  output logic [3:0]                     M_AXI_WSTRB,
  output logic                           M_AXI_WVALID,
  input  logic                           M_AXI_WREADY,
  input  logic [1:0]                     M_AXI_BRESP,
  input  logic                           M_AXI_BVALID,
  output logic                           M_AXI_BREADY,
  output logic [31:0]                    M_AXI_ARADDR,
  output logic                           M_AXI_ARVALID,
  input  logic                           M_AXI_ARREADY,
  input  logic [31:0]                    M_AXI_RDATA,
  input  logic [1:0]                     M_AXI_RRESP,
  input  logic                           M_AXI_RVALID,
  output logic                           M_AXI_RREADY,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [1:0]                     err_code,
  output logic [$clog2(MAX_WORDS+1)-1:0] words_loaded
);

  localparam int          WL_W     = $clog2(MAX_WORDS+1);
  localparam logic [31:0] CTRL_OFF = 32'h0000_0000;
  localparam logic [31:0] PC_OFF   = 32'h0000_0008;
  localparam logic [1:0]  ERR_BRESP = 2'b01;
  localparam logic [1:0]  ERR_OVFL  = 2'b10;
  localparam logic [1:0]  ERR_RDBK  = 2'b11;

  // RD_ADDR / RD_DATA are only reachable in the readback build.
  typedef enum logic [3:0] {
    S_IDLE, S_HALT, S_WAIT_WORD, S_PROG, S_DRAIN,
    S_RD_ADDR, S_RD_DATA, S_PC, S_RUN, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_n;

  logic        wr_req;
  logic [31:0] wr_addr_n, wr_data_n;
  logic        aw_done_q, w_done_q;
  logic        b_fire, bresp_bad;
  logic        rd_req;
  logic        word_ok;
  logic        start_acc, set_done, set_error, set_code, inc_words, latch_word;
  logic [1:0]  code_n;
  logic [31:0] word_q;
  logic        last_q;
  logic [31:0] prog_addr;

  assign M_AXI_WSTRB = 4'hF;
  assign b_fire      = M_AXI_BREADY && M_AXI_BVALID;
  assign bresp_bad   = b_fire && (M_AXI_BRESP != 2'b00);
  assign prog_addr   = BASE_ADDR + INSTR_OFF + 32'({words_loaded, 2'b00});

`ifdef CPU_LOADER_READBACK_EN
  logic ar_hs, r_fire;
  assign ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_fire = M_AXI_RREADY && M_AXI_RVALID;
`endif

  // State register
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) state_q <= S_IDLE;
    else              state_q <= state_n;
  end

  // Next-state logic, write/read requests and status strobes
  always_comb begin
    state_n      = state_q;
    wr_req       = 1'b0;
    wr_addr_n    = BASE_ADDR + CTRL_OFF;
    wr_data_n    = 32'h0;
    rd_req       = 1'b0;
    word_ok      = 1'b0;
    start_acc    = 1'b0;
    set_done     = 1'b0;
    set_error    = 1'b0;
    set_code     = 1'b0;
    code_n       = 2'b00;
    inc_words    = 1'b0;
    latch_word   = 1'b0;
    s_word_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          wr_req    = 1'b1;
          state_n   = S_HALT;
        end
      end
      S_HALT: begin
        if (bresp_bad) begin
          set_code = 1'b1; code_n = ERR_BRESP; set_error = 1'b1; state_n = S_ERROR;
        end else if (b_fire) begin
          state_n = S_WAIT_WORD;
        end
      end
      S_WAIT_WORD: begin
        s_word_ready = 1'b1;
        if (s_word_valid) begin
          latch_word = 1'b1;
          if (words_loaded == WL_W'(MAX_WORDS)) begin
            set_code = 1'b1;
            code_n   = ERR_OVFL;
            if (s_word_last) begin
              set_error = 1'b1;
              state_n   = S_ERROR;
            end else begin
              state_n = S_DRAIN;
            end
          end else begin
            wr_req    = 1'b1;
            wr_addr_n = prog_addr;
            wr_data_n = s_word_data;
            state_n   = S_PROG;
          end
        end
      end
      S_DRAIN: begin
        s_word_ready = 1'b1;
        if (s_word_valid && s_word_last) begin
          set_error = 1'b1;
          state_n   = S_ERROR;
        end
      end
      S_PROG: begin
        if (bresp_bad) begin
          set_code = 1'b1; code_n = ERR_BRESP; set_error = 1'b1; state_n = S_ERROR;
        end else if (b_fire) begin
`ifdef CPU_LOADER_READBACK_EN
          rd_req  = 1'b1;
          state_n = S_RD_ADDR;
`else
          word_ok = 1'b1;
`endif
        end
      end
`ifdef CPU_LOADER_READBACK_EN
      S_RD_ADDR: begin
        if (ar_hs) state_n = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (r_fire) begin
          if ((M_AXI_RDATA != word_q) || (M_AXI_RRESP != 2'b00)) begin
            set_code = 1'b1; code_n = ERR_RDBK; set_error = 1'b1; state_n = S_ERROR;
          end else begin
            word_ok = 1'b1;
          end
        end
      end
`endif
      S_PC: begin
        if (bresp_bad) begin
          set_code = 1'b1; code_n = ERR_BRESP; set_error = 1'b1; state_n = S_ERROR;
        end else if (b_fire) begin
          wr_req    = 1'b1;
          wr_addr_n = BASE_ADDR + CTRL_OFF;
          wr_data_n = RUN_CTRL;
          state_n   = S_RUN;
        end
      end
      S_RUN: begin
        if (bresp_bad) begin
          set_code = 1'b1; code_n = ERR_BRESP; set_error = 1'b1; state_n = S_ERROR;
        end else if (b_fire) begin
          set_done = 1'b1;
          state_n  = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERROR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // A program word is committed: count it, then either fetch the next one or set the PC.
    if (word_ok) begin
      inc_words = 1'b1;
      if (last_q) begin
        wr_req    = 1'b1;
        wr_addr_n = BASE_ADDR + PC_OFF;
        wr_data_n = START_PC;
        state_n   = S_PC;
      end else begin
        state_n = S_WAIT_WORD;
      end
    end
  end

  // Host-visible status: busy, sticky done/error, error code and word count
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'b00;
      words_loaded <= '0;
    end else begin
      if (start_acc) begin
        busy         <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
        err_code     <= 2'b00;
        words_loaded <= '0;
      end
      if (set_done) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (set_error) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end
      if (set_code)  err_code     <= code_n;
      if (inc_words) words_loaded <= words_loaded + WL_W'(1);
    end
  end

  // Accepted stream word, held for the write, readback compare and last-word decision
  always_ff @(posedge M_AXI_ACLK) begin
    if (latch_word) begin
      word_q <= s_word_data;
      last_q <= s_word_last;
    end
  end

  // Write engine: AW and W raised together, each dropped after its own handshake,
  // BREADY raised once both are done and dropped after the response
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_AWADDR  <= 32'h0;
      M_AXI_WDATA   <= 32'h0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
    end else if (wr_req) begin
      M_AXI_AWVALID <= 1'b1;
      M_AXI_WVALID  <= 1'b1;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_AWADDR  <= wr_addr_n;
      M_AXI_WDATA   <= wr_data_n;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
    end else begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        M_AXI_AWVALID <= 1'b0;
        aw_done_q     <= 1'b1;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        M_AXI_WVALID <= 1'b0;
        w_done_q     <= 1'b1;
      end
      if (aw_done_q && w_done_q && !M_AXI_BREADY) M_AXI_BREADY <= 1'b1;
      if (b_fire) begin
        M_AXI_BREADY <= 1'b0;
        aw_done_q    <= 1'b0;
        w_done_q     <= 1'b0;
      end
    end
  end

`ifdef CPU_LOADER_READBACK_EN
  // Read engine: ARVALID until ARREADY, then RREADY until RVALID
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      M_AXI_ARADDR  <= 32'h0;
    end else if (rd_req) begin
      M_AXI_ARVALID <= 1'b1;
      M_AXI_ARADDR  <= M_AXI_AWADDR;
    end else if (ar_hs) begin
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b1;
    end else if (r_fire) begin
      M_AXI_RREADY <= 1'b0;
    end
  end
`else
  logic unused_rd;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;
  assign M_AXI_ARADDR  = 32'h0;
  assign unused_rd     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
                           rd_req, word_q};
`endif

endmodule

// File: tb/tb_cpu_axi_program_loader.sv
// Testbench for cpu_axi_program_loader: table of load scenarios plus randomized
// loads, checked against a transaction-level model of the expected write sequence.
module tb_cpu_axi_program_loader;

  localparam int MAXW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_word_valid = 1'b0;
  logic        s_word_ready;
  logic [31:0] s_word_data = 32'h0;
  logic        s_word_last = 1'b0;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [3:0]  WSTRB;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
  logic        ARREADY = 1'b0, RVALID = 1'b0;
  logic [31:0] RDATA = 32'h0;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [4:0]  words_loaded;

  cpu_axi_program_loader dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .start(start),
    .s_word_valid(s_word_valid), .s_word_ready(s_word_ready),
    .s_word_data(s_word_data), .s_word_last(s_word_last),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n; int fail_at; int awd; int wd; int bd;
    bit gaps; bit x_start; bit done_start; bit chk_log;
    bit e_done; bit e_err; int e_code; int e_wl;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] words [32];
  logic [31:0] log_a[$], log_d[$], exp_a[$], exp_d[$];
  int cfg_awd = 0, cfg_wd = 0, cfg_bd = 0, cfg_fail = -1;
  logic [31:0] cfg_corrupt = 32'hFFFF_FFFF;
  int viol = 0, wr_cnt = 0;
  int src_idx = 0;
  bit acc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // AXI-Lite slave model: decisions made on the falling edge, so a handshake
  // decided here completes on the following rising edge.
  initial begin : slave
    bit got_aw, got_w, b_pend, p_awv, p_wv, p_aw_hs, p_w_hs;
    int awc, wc, bc;
    logic [31:0] s_addr, s_data, p_awa, p_wd;
    logic [31:0] mem [logic [31:0]];
    bit ar_pend, r_pend;
    logic [31:0] ra;
    got_aw = 0; got_w = 0; b_pend = 0; p_awv = 0; p_wv = 0; p_aw_hs = 0; p_w_hs = 0;
    awc = 0; wc = 0; bc = 0; s_addr = 0; s_data = 0; p_awa = 0; p_wd = 0;
    ar_pend = 0; r_pend = 0; ra = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        got_aw = 0; got_w = 0; b_pend = 0; p_awv = 0; p_wv = 0; p_aw_hs = 0; p_w_hs = 0;
        awc = 0; wc = 0; bc = 0; ar_pend = 0; r_pend = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        continue;
      end
      if (b_pend) begin
        BVALID = 0; b_pend = 0; got_aw = 0; got_w = 0; bc = 0;
      end
      if (p_awv && !p_aw_hs && (!AWVALID || AWADDR != p_awa)) viol++;
      if (p_wv && !p_w_hs && (!WVALID || WDATA != p_wd)) viol++;
      if (AWVALID && got_aw) viol++;
      if (WVALID && got_w) viol++;
      if (BREADY && !(got_aw && got_w)) viol++;
      if (WVALID && WSTRB != 4'hF) viol++;
      if (got_aw && got_w && !BVALID) begin
        if (bc < cfg_bd) bc++;
        else begin
          BVALID = 1;
          BRESP  = (wr_cnt == cfg_fail) ? 2'b10 : 2'b00;
        end
      end
      if (BVALID && BREADY) begin
        b_pend = 1;
        log_a.push_back(s_addr);
        log_d.push_back(s_data);
        mem[s_addr] = s_data;
        wr_cnt++;
      end
      AWREADY = 0;
      if (AWVALID && !got_aw) begin
        if (awc < cfg_awd) awc++;
        else AWREADY = 1;
      end
      p_aw_hs = AWVALID && AWREADY;
      if (p_aw_hs) begin got_aw = 1; s_addr = AWADDR; awc = 0; end
      WREADY = 0;
      if (WVALID && !got_w) begin
        if (wc < cfg_wd) wc++;
        else WREADY = 1;
      end
      p_w_hs = WVALID && WREADY;
      if (p_w_hs) begin got_w = 1; s_data = WDATA; wc = 0; end
      p_awv = AWVALID; p_awa = AWADDR; p_wv = WVALID; p_wd = WDATA;
      if (r_pend) begin RVALID = 0; r_pend = 0; end
      if (ar_pend) begin
        ar_pend = 0; ARREADY = 0; RVALID = 1; RRESP = 2'b00;
        RDATA = (ra == cfg_corrupt) ? 32'hDEADBEEF : (mem.exists(ra) ? mem[ra] : 32'h0);
      end else begin
        ARREADY = ARVALID && !RVALID;
        if (ARVALID && ARREADY) begin ar_pend = 1; ra = ARADDR; end
      end
      if (RVALID && RREADY) r_pend = 1;
    end
  end

  // Expected write sequence and final status of one load, from the load rules.
  task automatic model(input int n, input int fail_at, output bit d, output bit e,
                       output int code, output int wl, output int cons);
    int w;
    w = 0; d = 0; e = 0; code = 0; wl = 0; cons = 0;
    exp_a.delete(); exp_d.delete();
    exp_a.push_back(32'h0); exp_d.push_back(32'h0);
    if (fail_at == w) begin e = 1; code = 1; return; end
    w++;
    for (int i = 0; i < n; i++) begin
      cons = i + 1;
      if (i >= MAXW) begin e = 1; code = 2; cons = n; return; end
      exp_a.push_back(32'h40 + 32'(4 * i)); exp_d.push_back(words[i]);
      if (fail_at == w) begin e = 1; code = 1; return; end
      w++;
      wl = i + 1;
    end
    exp_a.push_back(32'h8); exp_d.push_back(32'h0);
    if (fail_at == w) begin e = 1; code = 1; return; end
    w++;
    exp_a.push_back(32'h0); exp_d.push_back(32'h1);
    if (fail_at == w) begin e = 1; code = 1; return; end
    d = 1;
  endtask

  task automatic run_load(input string tag, input vec_t v);
    bit md, me, finished;
    int mc, mw, mcons, nlog;
    model(v.n, v.fail_at, md, me, mc, mw, mcons);
    cfg_awd = v.awd; cfg_wd = v.wd; cfg_bd = v.bd; cfg_fail = v.fail_at;
    log_a.delete(); log_d.delete(); wr_cnt = 0; viol = 0;
    src_idx = 0; acc = 0; s_word_valid = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    finished = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done || error) begin finished = 1; break; end
      start = v.x_start && (c == 6);
      if (acc) begin src_idx++; s_word_valid = 0; acc = 0; end
      if (src_idx < v.n) begin
        if (!s_word_valid) s_word_valid = v.gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
        s_word_data = words[src_idx];
        s_word_last = (src_idx == v.n - 1);
      end else begin
        s_word_valid = 0;
      end
      if (s_word_valid && s_word_ready) acc = 1;
      @(negedge clk);
    end
    start = 0;
    if (acc) src_idx++;
    acc = 0; s_word_valid = 0;
    check({tag, " finished"}, 32'(finished), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'(v.e_done));
    check({tag, " error"}, 32'(error), 32'(v.e_err));
    check({tag, " err_code"}, 32'(err_code), 32'(v.e_code));
    check({tag, " words_loaded"}, 32'(words_loaded), 32'(v.e_wl));
    check({tag, " protocol"}, 32'(viol), 32'd0);
`ifndef CPU_LOADER_READBACK_EN
    check({tag, " arvalid"}, 32'({ARVALID, RREADY}), 32'd0);
`endif
    if (v.chk_log) begin
      check({tag, " nwrites"}, 32'(log_a.size()), 32'(exp_a.size()));
      check({tag, " consumed"}, 32'(src_idx), 32'(mcons));
      nlog = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
      for (int i = 0; i < nlog; i++) begin
        check($sformatf("%s wr%0d addr", tag, i), log_a[i], exp_a[i]);
        check($sformatf("%s wr%0d data", tag, i), log_d[i], exp_d[i]);
      end
    end
    if (v.done_start && done) begin
      start = 1;
      @(negedge clk); start = 0;
      @(negedge clk);
      check({tag, " start_at_done busy"}, 32'(busy), 32'd0);
      check({tag, " start_at_done done"}, 32'(done), 32'd1);
    end
    repeat (2) @(negedge clk);
  endtask

  vec_t vt [9];

  initial begin : main
    vec_t v;
    bit md, me;
    int mc, mw, mcons;
    vt[0] = '{3,  -1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 3};
    vt[1] = '{3,  -1, 3, 0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 3};
    vt[2] = '{17, -1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 16};
    vt[3] = '{3,   2, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1};
    vt[4] = '{16, -1, 1, 2, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 16};
    vt[5] = '{1,   0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0};
    vt[6] = '{2,   4, 2, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 2};
    vt[7] = '{20, -1, 0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 16};
    vt[8] = '{4,   5, 1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 4};

    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done_error", 32'({done, error}), 32'd0);
    check("reset err_code", 32'(err_code), 32'd0);
    check("reset words_loaded", 32'(words_loaded), 32'd0);
    check("reset valids", 32'({AWVALID, WVALID, ARVALID}), 32'd0);
    check("reset readies", 32'({BREADY, RREADY, s_word_ready}), 32'd0);
    check("reset awaddr", AWADDR, 32'h0);
    check("reset wdata", WDATA, 32'h0);
    check("reset araddr", ARADDR, 32'h0);
    rst = 0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 32; i++) words[i] = $urandom;
      if (k < 2) begin
        words[0] = 32'h00500093; words[1] = 32'h00A00113; words[2] = 32'h002081B3;
      end
      run_load($sformatf("vec%0d", k), vt[k]);
    end

    // Reset while the HALT write is outstanding, then a clean load.
    cfg_awd = 8; cfg_wd = 8; cfg_bd = 0; cfg_fail = -1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 20 && !AWVALID; c++) @(negedge clk);
    check("rstmid awvalid seen", 32'(AWVALID), 32'd1);
    #1 rst = 1;
    #1;
    check("rstmid valids", 32'({AWVALID, WVALID, ARVALID}), 32'd0);
    check("rstmid readies", 32'({BREADY, RREADY, s_word_ready}), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk); rst = 0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    run_load("after_reset", '{3, -1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 3});

    // Randomized loads, expectations taken from the model.
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 32; i++) words[i] = $urandom;
      v.n = $urandom_range(1, 20);
      v.fail_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, v.n + 2)) : -1;
      v.awd = $urandom_range(0, 3); v.wd = $urandom_range(0, 3); v.bd = $urandom_range(0, 3);
      v.gaps = 1'($urandom_range(0, 1)); v.x_start = 1'($urandom_range(0, 1));
      v.done_start = 1'b0; v.chk_log = 1'b1;
      model(v.n, v.fail_at, md, me, mc, mw, mcons);
      v.e_done = md; v.e_err = me; v.e_code = mc; v.e_wl = mw;
      run_load($sformatf("rnd%0d", k), v);
    end

`ifdef CPU_LOADER_READBACK_EN
    // Slave corrupts the readback of word 1.
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    cfg_corrupt = 32'h44;
    run_load("rdbk", '{3, -1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1});
    check("rdbk nwrites", 32'(log_a.size()), 32'd3);
    cfg_corrupt = 32'hFFFF_FFFF;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
